// File: rtl/fir_bank_pkg.sv
// Shared types and default widths for the multi-bank FIR engine.
// Holds the FSM state enum and the default-width saturation limits.
package fir_bank_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_COEF_W = 32;
    localparam int DEF_FRAC   = 16;
    localparam int DEF_TAPS   = 23;
    localparam int DEF_NBANKS = 4;

    // Clamp values for a DEF_DATA_W-wide signed result
    localparam logic [DEF_DATA_W-1:0] SAT_HI =
        {1'b0, {(DEF_DATA_W-1){1'b1}}};
    localparam logic [DEF_DATA_W-1:0] SAT_LO =
        {1'b1, {(DEF_DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        RND,
        BYP,
        OUT
    } state_t;

endpackage

// File: rtl/fir_sat_round.sv
// Scales the accumulator down by FRAC (floor) and clamps to DATA_W.
// Ports: acc (ACC_W signed in), res (DATA_W out), sat (clamp happened).
module fir_sat_round
    import fir_bank_pkg::*;
#(
    parameter int ACC_W  = 53,
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC   = DEF_FRAC
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic        [DATA_W-1:0] res,
    output logic                     sat
);

    localparam logic signed [ACC_W-1:0] HI =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] LO =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] sh;

    always_comb begin
        sh  = acc >>> FRAC;
        res = sh[DATA_W-1:0];
        sat = 1'b0;
        if (sh > HI) begin
            res = HI[DATA_W-1:0];
            sat = 1'b1;
        end else if (sh < LO) begin
            res = LO[DATA_W-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/fir_bank_engine.sv
// Time-multiplexed MAC FIR with NBANKS runtime-loadable coefficient banks,
// an internal sample-history ring and valid/ready streams on both sides.
// Ports: clk, rst (async, high); in_valid/in_ready/in_data/bank_sel;
// out_valid/out_ready/out_data/out_sat; coef_we/coef_bank/coef_idx/
// coef_data/coef_wr_err; hist_clr.
module fir_bank_engine
    import fir_bank_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int FRAC   = DEF_FRAC,
    parameter int TAPS   = DEF_TAPS,
    parameter int NBANKS = DEF_NBANKS,
    parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [$clog2(NBANKS):0]   bank_sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_sat,
    input  logic                      coef_we,
    input  logic [$clog2(NBANKS)-1:0] coef_bank,
    input  logic [$clog2(TAPS)-1:0]   coef_idx,
    input  logic [COEF_W-1:0]         coef_data,
    output logic                      coef_wr_err,
    input  logic                      hist_clr
);

    localparam int IDX_W  = $clog2(TAPS);
    localparam int BANK_W = $clog2(NBANKS);
    localparam int BSEL_W = BANK_W + 1;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic [IDX_W-1:0]  LAST  = IDX_W'(TAPS - 1);
    localparam logic [BSEL_W-1:0] NB    = BSEL_W'(NBANKS);
    localparam logic [IDX_W:0]    NTAPS = (IDX_W+1)'(TAPS);

    state_t state_q, state_d;

    logic signed [DATA_W-1:0] hist [TAPS];
    logic signed [COEF_W-1:0] coef [NBANKS][TAPS];

    logic [IDX_W-1:0]        wptr, rptr, k;
    logic [BSEL_W-1:0]       bank_q;
    logic signed [ACC_W-1:0] acc;
    logic [DATA_W-1:0]       out_data_q;
    logic                    out_sat_q;
    logic                    err_q;

    logic                     accept, do_clr;
    logic                     busy_bank, idx_bad, coef_ok;
    logic [BANK_W-1:0]        bsel;
    logic signed [DATA_W-1:0] smp;
    logic signed [COEF_W-1:0] cf;
    logic signed [PROD_W-1:0] xs, cs, prod;
    logic [DATA_W-1:0]        rnd_data;
    logic                     rnd_sat;

    assign in_ready    = (state_q == IDLE) & ~hist_clr;
    assign accept      = in_valid & in_ready;
    assign do_clr      = (state_q == IDLE) & hist_clr;
    assign out_valid   = (state_q == OUT);
    assign out_data    = out_data_q;
    assign out_sat     = out_sat_q;
    assign coef_wr_err = err_q;

    // Only the bank being summed right now is write-protected
    assign busy_bank = ((state_q == MAC) | (state_q == RND))
                     & ({1'b0, coef_bank} == bank_q);
    assign idx_bad   = {1'b0, coef_idx} >= NTAPS;
    assign coef_ok   = coef_we & ~idx_bad & ~busy_bank;

    assign bsel = bank_q[BANK_W-1:0];
    assign smp  = hist[rptr];
    assign cf   = coef[bsel][k];
    assign xs   = {{COEF_W{smp[DATA_W-1]}}, smp};
    assign cs   = {{DATA_W{cf[COEF_W-1]}}, cf};
    assign prod = xs * cs;

    fir_sat_round #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .FRAC   (FRAC)
    ) u_rnd (
        .acc (acc),
        .res (rnd_data),
        .sat (rnd_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = (bank_sel >= NB) ? BYP : MAC;
            MAC:  if (k == LAST) state_d = RND;
            RND:  state_d = OUT;
            BYP:  state_d = OUT;
            OUT:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) hist[i] <= '0;
            wptr       <= '0;
            rptr       <= '0;
            k          <= '0;
            acc        <= '0;
            bank_q     <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            if (do_clr) begin
                for (int i = 0; i < TAPS; i++) hist[i] <= '0;
                wptr <= '0;
            end else if (accept) begin
                hist[wptr] <= in_data;
                bank_q     <= bank_sel;
                rptr       <= wptr;
                k          <= '0;
                acc        <= '0;
                wptr       <= (wptr == LAST) ? '0 : wptr + 1'b1;
            end
            if (state_q == MAC) begin
                acc  <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
                rptr <= (rptr == '0) ? LAST : rptr - 1'b1;
                k    <= k + 1'b1;
            end
            if (state_q == RND) begin
                out_data_q <= rnd_data;
                out_sat_q  <= rnd_sat;
            end
            // rptr still points at the slot the bypass sample went into
            if (state_q == BYP) begin
                out_data_q <= smp;
                out_sat_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NBANKS; b++)
                for (int t = 0; t < TAPS; t++)
                    coef[b][t] <= '0;
            err_q <= 1'b0;
        end else begin
            if (coef_ok) coef[coef_bank][coef_idx] <= coef_data;
            err_q <= coef_we & (idx_bad | busy_bank);
        end
    end

endmodule

// File: tb/tb_fir_bank_engine.sv
// Self-checking bench for fir_bank_engine: vector table plus scoreboard,
// and directed sequences for reset abort, backpressure and coef errors.
module tb_fir_bank_engine;
    import fir_bank_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [2:0]  bank_sel = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_sat;
    logic        coef_we = 1'b0;
    logic [1:0]  coef_bank = '0;
    logic [4:0]  coef_idx = '0;
    logic [31:0] coef_data = '0;
    logic        coef_wr_err;
    logic        hist_clr = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] d;
        logic        s;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic        clr;
        logic [15:0] din;
        logic [2:0]  bank;
        logic [15:0] dout;
        logic        s;
        int          lat;
    } vec_t;

    exp_t q[$];
    vec_t tbl[$];

    fir_bank_engine dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .bank_sel    (bank_sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sat     (out_sat),
        .coef_we     (coef_we),
        .coef_bank   (coef_bank),
        .coef_idx    (coef_idx),
        .coef_data   (coef_data),
        .coef_wr_err (coef_wr_err),
        .hist_clr    (hist_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, want);
        end
    endtask

    // Scoreboard: latency on the rising edge of out_valid, data on handshake
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid && !prev_v) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out got=%0h want=none",
                             out_data);
                end else if (cyc - q[0].acc != q[0].lat) begin
                    bad++;
                    $display("FAIL latency got=%0d want=%0d",
                             cyc - q[0].acc, q[0].lat);
                end
            end
            if (out_valid && out_ready && q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (out_data !== e.d || out_sat !== e.s) begin
                    bad++;
                    $display("FAIL result got=%0h/%0b want=%0h/%0b",
                             out_data, out_sat, e.d, e.s);
                end
            end
        end
        prev_v = out_valid;
    end

    task automatic wcoef(input logic [1:0] b, input logic [4:0] i,
                         input logic [31:0] d);
        @(posedge clk); #1;
        coef_we = 1'b1; coef_bank = b; coef_idx = i; coef_data = d;
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic [2:0] b,
                        input logic [15:0] ed, input logic es,
                        input int lat, input logic clr, input bit push);
        int n;
        n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d; bank_sel = b; hist_clr = clr;
        if (clr) begin
            @(negedge clk);
            check("clr_blocks_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            hist_clr = 1'b0;
        end
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout got=busy want=ready");
        end else if (push) begin
            q.push_back('{ed, es, lat, cyc});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((q.size() != 0 || !in_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (q.size() != 0 || !in_ready) begin
            bad++;
            $display("FAIL idle_timeout got=pending%0d want=pending0",
                     q.size());
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=running want=done");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        logic [15:0] held;
        int n;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_out_sat", {31'd0, out_sat}, 32'd0);
        check("rst_wr_err", {31'd0, coef_wr_err}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        wcoef(2'd0, 5'd0, 32'h0001_0000);
        for (int t = 0; t < 23; t++) wcoef(2'd1, 5'(t), 32'(t) << 16);
        for (int t = 0; t < 23; t++) wcoef(2'd2, 5'(t), 32'h0001_0000);
        @(negedge clk);
        check("idle_wr_no_err", {31'd0, coef_wr_err}, 32'd0);

        wcoef(2'd1, 5'd23, 32'h1234);
        @(negedge clk);
        check("idx23_err", {31'd0, coef_wr_err}, 32'd1);
        @(negedge clk);
        check("idx23_err_pulse", {31'd0, coef_wr_err}, 32'd0);

        tbl.push_back('{1'b0, 16'h0100, 3'd0, 16'h0100, 1'b0, 25});
        tbl.push_back('{1'b0, 16'h0200, 3'd0, 16'h0200, 1'b0, 25});
        tbl.push_back('{1'b0, 16'h1234, 3'd7, 16'h1234, 1'b0, 2});
        tbl.push_back('{1'b1, 16'h0001, 3'd1, 16'h0000, 1'b0, 25});
        for (int t = 1; t < 23; t++)
            tbl.push_back('{1'b0, 16'h0000, 3'd1, 16'(t), 1'b0, 25});
        tbl.push_back('{1'b0, 16'h0001, 3'd1, 16'h0000, 1'b0, 25});
        tbl.push_back('{1'b1, 16'h0000, 3'd1, 16'h0000, 1'b0, 25});
        tbl.push_back('{1'b1, 16'h7FFF, 3'd2, 16'h7FFF, 1'b0, 25});
        tbl.push_back('{1'b0, 16'h7FFF, 3'd2, SAT_HI, 1'b1, 25});
        tbl.push_back('{1'b1, 16'h8000, 3'd2, 16'h8000, 1'b0, 25});
        tbl.push_back('{1'b0, 16'h8000, 3'd2, SAT_LO, 1'b1, 25});

        foreach (tbl[i]) begin
            if (tbl[i].clr) wait_idle();
            send(tbl[i].din, tbl[i].bank, tbl[i].dout, tbl[i].s,
                 tbl[i].lat, tbl[i].clr, 1'b1);
        end
        wait_idle();

        // Backpressure: result parked in OUT, new offers ignored
        @(posedge clk); #1 out_ready = 1'b0;
        send(16'h4321, 3'd7, 16'h4321, 1'b0, 2, 1'b0, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 16'h1111; bank_sel = 3'd7;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (!out_valid || out_data !== 16'h4321 || in_ready)
                seen = 1'b1;
        end
        check("bp_stable", {31'd0, seen}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        wait_idle();
        repeat (5) @(negedge clk);

        // Writes during MAC: active bank rejected, other bank taken
        send(16'h0300, 3'd0, 16'h0300, 1'b0, 25, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        coef_we = 1'b1; coef_bank = 2'd0; coef_idx = 5'd0; coef_data = '0;
        @(posedge clk); #1;
        coef_bank = 2'd3; coef_data = 32'h0002_0000;
        @(negedge clk);
        check("mac_active_err", {31'd0, coef_wr_err}, 32'd1);
        @(posedge clk); #1 coef_we = 1'b0;
        @(negedge clk);
        check("mac_other_no_err", {31'd0, coef_wr_err}, 32'd0);
        wait_idle();
        send(16'h0010, 3'd3, 16'h0020, 1'b0, 25, 1'b0, 1'b1);
        send(16'h0007, 3'd0, 16'h0007, 1'b0, 25, 1'b0, 1'b1);
        wait_idle();

        // Reset at MAC cycle 10 aborts the sum
        send(16'h0400, 3'd0, 16'h0000, 1'b0, 0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_valid_low", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_out", {31'd0, seen}, 32'd0);
        held = out_data;
        check("abort_data_clr", {16'd0, held}, 32'd0);
        wcoef(2'd0, 5'd0, 32'h0001_0000);
        send(16'h0100, 3'd0, 16'h0100, 1'b0, 25, 1'b0, 1'b1);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_bank_engine.md
Name: fir_bank_engine

Overview:
- Parametrised successor to the single-filter FIR path: one time-multiplexed MAC engine serves NBANKS coefficient banks instead of three fixed filter instances.
- Built-in sample history ring buffer, runtime coefficient load and a valid/ready stream interface on both sides.
- Sits between the ADC sample stream and the display/trigger path of the oscilloscope.
- Replaces the external history and coefficient BRAMs, the address muxes and the start-pulse logic.

Parameters:
- DATA_W, 16, sample and result width (signed two's complement).
- COEF_W, 32, coefficient width, signed fixed point with FRAC fractional bits.
- FRAC, 16, fractional bits of coefficients.
- TAPS, 23, filter length and history depth.
- NBANKS, 4, number of coefficient banks.
- ACC_W, DATA_W+COEF_W+$clog2(TAPS), accumulator width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  sample offered.
- in_ready  out  1  engine can accept a sample.
- in_data  in  DATA_W  input sample.
- bank_sel  in  $clog2(NBANKS)+1  filter select. Values >= NBANKS mean bypass.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  DATA_W  filtered sample.
- out_sat  out  1  result was saturated; qualified by out_valid.
- coef_we  in  1  coefficient write strobe.
- coef_bank  in  $clog2(NBANKS)  coefficient bank to write.
- coef_idx  in  $clog2(TAPS)  tap index to write.
- coef_data  in  COEF_W  coefficient value.
- coef_wr_err  out  1  one-cycle pulse: write was rejected.
- hist_clr  in  1  zero the sample history.

Behaviour:
- Reset (asynchronous):
  - state=IDLE; history, all coefficients, wptr, tap counter and accumulator cleared.
  - Outputs: out_valid=0, out_data=0, out_sat=0, coef_wr_err=0.
- in_ready = (state==IDLE) & ~hist_clr. It is combinational and is high in the first cycle after reset release.
- IDLE, on in_valid & in_ready:
  - Write in_data to hist[wptr].
  - Latch bank_sel into bank_q.
  - Set rptr=wptr, k=0, acc=0.
  - wptr advances by one and wraps from TAPS-1 to 0.
  - Next state is MAC, or BYP if bank_sel >= NBANKS.
- MAC, one tap per cycle:
  - acc += sext(hist[rptr]) * coef[bank_q][k].
  - rptr decrements and wraps from 0 to TAPS-1; k increments.
  - After the k==TAPS-1 product, go to RND.
- RND:
  - res = acc >>> FRAC (arithmetic shift, truncation toward -inf).
  - If res > 2^(DATA_W-1)-1 or res < -2^(DATA_W-1): clamp, set out_sat=1; otherwise out_sat=0.
  - Next state is OUT.
- BYP: out_data=sample, out_sat=0, next state is OUT.
- OUT:
  - out_valid=1; out_data and out_sat are held stable.
  - On out_ready, go to IDLE with out_valid=0.
  - out_data keeps its last value after the handshake.
- Latency: sample accepted at cycle 0 gives out_valid at cycle TAPS+2 (filter) or cycle 2 (bypass). Throughput is one sample per TAPS+3 cycles when out_ready is held high.
- Coefficient writes:
  - Applied in any state except MAC/RND with the same bank as bank_q.
  - A write to the bank in use is dropped and coef_wr_err pulses the next cycle.
  - coef_idx >= TAPS is dropped with coef_wr_err.
- hist_clr:
  - Honoured only in IDLE: zeros all history entries and wptr in one cycle.
  - If it coincides with in_valid, no sample is accepted that cycle.
  - Ignored outside IDLE.
- Changing bank_sel mid-computation has no effect until the next sample.
- Reset mid-MAC aborts the computation; no out_valid is produced.

Decomposition:
- Package fir_bank_pkg holds:
  - state enum (IDLE, MAC, RND, BYP, OUT);
  - the default widths;
  - the saturation limit helper constants.
- One natural sub-module: fir_sat_round (combinational shift plus clamp, ACC_W to DATA_W, sat flag). The ring buffer stays inline.

Test Plan:
- Identity, bypass and reset:
  - Identity: coef[0][0]=0x00010000, others 0; bank_sel=0; inputs 0x0100, 0x0200 -> outputs 0x0100, 0x0200, each with out_valid 25 cycles after acceptance, out_sat=0.
  - Bypass: bank_sel=7; input 0x1234 -> out_data=0x1234 two cycles later; coefficients unused.
  - Reset mid-MAC: assert rst at cycle 10 of MAC -> out_valid never rises, in_ready=1 after release, the next identity sample is correct.
- Impulse and history:
  - Impulse response: bank1 coef[k]=k*0x00010000; input 0x0001 then 22 zeros -> outputs 0,1,2,...,22 (sample n yields n).
  - hist_clr: after the impulse sequence, pulse hist_clr in IDLE, then one zero input -> output 0.
- Saturation: bank2 all coefs 0x00010000; two inputs 0x7FFF -> second output 0x7FFF with out_sat=1. Two inputs 0x8000 -> 0x8000 with out_sat=1.
- Handshake and coefficient errors:
  - Backpressure: hold out_ready=0 for 10 cycles in OUT -> out_valid and out_data stable, in_ready=0, in_valid ignored.
  - Write to active bank during MAC -> coef_wr_err pulses, result unchanged.
  - Write with coef_idx=23 -> coef_wr_err pulses.
